// File: rtl/core_pkg.sv
// Shared core constants: fetch geometry, NOP encoding
// and the base opcodes decode switches on.
package core_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int unsigned PC_STEP = 4;
  localparam int unsigned FETCH_DEPTH = 2;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011,
    OP_SYSTEM = 7'b1110011
  } opcode_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-to-decode valid/ready channel carrying
// the PC/instruction pair.
interface fetch_unit_if #(
  parameter int ADDRESS_BITS = 16
);
  logic                    inst_valid;
  logic                    inst_ready;
  logic [ADDRESS_BITS-1:0] PC;
  logic [31:0]             instruction;

  modport master (
    output inst_valid,
    output PC,
    output instruction,
    input  inst_ready
  );

  modport slave (
    input  inst_valid,
    input  PC,
    input  instruction,
    output inst_ready
  );
endinterface

// File: rtl/fetch_buffer.sv
// Two-entry {PC, word} queue; slot e0 is always the head.
// flush beats push; pop and flush may coincide.
module fetch_buffer
  import core_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [AW-1:0] push_pc,
  input  logic [31:0]   push_word,
  output logic [1:0]    count,
  output logic [AW-1:0] head_pc,
  output logic [31:0]   head_word
);

  logic [AW+31:0] e0, e1;
  logic [1:0]     fill;
  logic           wr_idx;

  assign fill   = count - {1'b0, pop};
  assign wr_idx = (fill != 2'd0);

  always_ff @(posedge clock) begin
    if (reset || flush)
      count <= '0;
    else
      count <= count + {1'b0, push} - {1'b0, pop};
    if (pop)
      e0 <= e1;
    if (push) begin
      if (wr_idx)
        e1 <= {push_pc, push_word};
      else
        e0 <= {push_pc, push_word};
    end
  end

  assign head_pc   = e0[AW+31:32];
  assign head_word = e0[31:0];

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC generation, imem request credit,
// response buffering and redirect squash.
module fetch_unit
  import core_pkg::*;
#(
  parameter int ADDRESS_BITS = 16,
  parameter logic [ADDRESS_BITS-1:0] RESET_PC = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    next_PC_select,
  input  logic [ADDRESS_BITS-1:0] target_PC,
  output logic                    imem_req,
  output logic [ADDRESS_BITS-1:0] imem_addr,
  input  logic [31:0]             imem_rdata,
  fetch_unit_if.master            dec
);

  localparam int AW = ADDRESS_BITS;

  logic [AW-1:0] fpc, issued_pc, head_pc, tgt;
  logic [31:0]   head_word;
  logic [1:0]    count;
  logic [2:0]    avail;
  logic          inflight, squash, resp;
  logic          has_buf, valid, pop;
  logic          buf_push, buf_pop, buf_flush;

  assign tgt     = target_PC & ~AW'(3);
  assign resp    = inflight && !squash;
  assign has_buf = (count != 2'd0);
  assign valid   = !reset && (has_buf || resp);
  assign pop     = valid && dec.inst_ready;

  // The arriving word counts as an occupied slot even
  // before it is written, so the queue never overflows.
  assign avail = {1'b0, count} + {2'b0, inflight}
               - {2'b0, pop};
  assign imem_req = !reset && !next_PC_select
                 && (avail < 3'(FETCH_DEPTH));
  assign imem_addr = fpc;

  assign buf_pop   = pop && has_buf;
  assign buf_push  = resp && !(pop && !has_buf);
  assign buf_flush = next_PC_select;

  fetch_buffer #(.AW(AW)) u_buf (
    .clock     (clock),
    .reset     (reset),
    .push      (buf_push),
    .pop       (buf_pop),
    .flush     (buf_flush),
    .push_pc   (issued_pc),
    .push_word (imem_rdata),
    .count     (count),
    .head_pc   (head_pc),
    .head_word (head_word)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      fpc       <= RESET_PC;
      issued_pc <= '0;
      inflight  <= 1'b0;
      squash    <= 1'b0;
    end else if (next_PC_select) begin
      fpc      <= tgt;
      inflight <= 1'b0;
      squash   <= inflight;
    end else begin
      squash   <= 1'b0;
      inflight <= imem_req;
      if (imem_req) begin
        issued_pc <= fpc;
        fpc       <= fpc + AW'(PC_STEP);
      end
    end
  end

  always_comb begin
    dec.inst_valid  = valid;
    dec.PC          = '0;
    dec.instruction = NOP;
    if (valid) begin
      dec.PC          = has_buf ? head_pc : issued_pc;
      dec.instruction = has_buf ? head_word : imem_rdata;
    end
  end

endmodule
